powlib_busxbar: RTL
===================

Name: powlib_busxbar

Overview:
Single-clock, parametrised successor to the multi-clock bus crossbar. It routes packed PLB words (data/be/op) from B_WRS bus masters to B_RDS bus slaves by address decode. Each slave port has its own round-robin arbiter and a registered output stage. Unmapped addresses are dropped with an error report. It sits between bus masters (e.g. the AXI slave bridge) and memory-mapped IP (RAMs, peripherals) in a single clock domain.

Parameters:
ID, "BUSXBAR", debug/assert string tag
EAR, 0, 1 = register inputs (adds one cycle on every path); 0 = inputs feed the arbiter directly
EDBG, 0, 1 = enable simulation display of grants and drops
B_WRS, 2, number of master (input) ports, >=1
B_RDS, 3, number of slave (output) ports, >=1
B_AW, 32, address width
B_DW, 40, packed word width (data+be+op)
B_BASES, {B_RDS{32'h0}}, concatenated B_AW-bit base address per slave; slave 0 in the LSBs
B_SIZES, {B_RDS{32'hFFFF}}, concatenated B_AW-bit inclusive span per slave
ERRW, 16, error counter width

Ports:
clk  in  1  clock; single clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
wraddrs  in  B_AW*B_WRS  master addresses
wrdatas  in  B_DW*B_WRS  master packed words
wrvlds  in  B_WRS  master valid
wrrdys  out  B_WRS  master ready
rdaddrs  out  B_AW*B_RDS  slave addresses (offset from the slave base)
rddatas  out  B_DW*B_RDS  slave packed words
rdvlds  out  B_RDS  slave valid
rdrdys  in  B_RDS  slave ready
errvld  out  1  one-cycle pulse per cycle in which at least one unmapped word is dropped
erraddr  out  B_AW  address of the lowest-index master dropped in that cycle
errcnt  out  ERRW  saturating count of dropped words

Behaviour:
- Reset: rdvlds=0, rdaddrs=0, rddatas=0, errvld=0, erraddr=0, errcnt=0, all RR pointers=0. Any word held in an output register is discarded.
- Decode: master i targets the lowest-index slave s with base_s <= addr <= base_s+size_s. Overlapping windows resolve to the lower index. The sum is computed at B_AW+1 bits, so there is no wrap.
- Output address: rdaddr = addr - base_s, truncated to B_AW bits.
- Per slave s:
  - Output register is "free" when rdvlds[s]=0, or when rdvlds[s]&rdrdys[s] in the same cycle.
  - Requesters are masters with wrvld set and decode equal to s.
  - The arbiter scans from ptr_s upward, modulo B_WRS. The first requester is granted.
- wrrdys[i]=1 when master i is granted by its target slave and that slave is free. wrrdys[i]=1 unconditionally when master i's address is unmapped (drop).
- Transfer on wrvld&wrrdy. The output register loads on the next edge, so latency is 1 cycle with EAR=0 and 2 cycles with EAR=1.
- ptr_s becomes (granted index+1) mod B_WRS only on a transfer. With no transfer, ptr_s holds.
- An output register holds data and address stable while rdvlds=1 and rdrdys=0.
- Throughput: one word per cycle per slave. Different slaves transfer in parallel in the same cycle.
- Drop: a drop does not affect any slave. errvld=1 on the next cycle. errcnt increments by popcount(dropped masters), saturating at 2^ERRW-1.
- Simultaneous drain and load on one slave: the new word replaces the old with no bubble.
- Masters not granted see wrrdys=0. They must hold wrvld/addr/data stable; the block may assume this.
- B_WRS=1: the arbiter degenerates to pass-through and the pointer is constant 0.

Test Plan:
- Single master, EAR=0, write addr 32'h44A00010 (slave 1 base 32'h44A00000), rdrdys=all 1 -> rdvlds[1]=1 exactly 1 cycle later, rdaddr=32'h10, data unchanged, other rdvlds=0.
- Masters 0 and 1 stream continuously to slave 0 with rdrdys[0]=1 -> grants alternate 0,1,0,1, and each master gets 1 word every 2 cycles.
- Backpressure: rdrdys[0]=0 for 5 cycles with a word held -> rddatas stable, wrrdys=0 for the requester. Release rdrdys[0] -> the next word appears the following cycle with no loss or duplication.
- Master 0 to slave 0 and master 1 to slave 2 in the same cycle -> both wrrdys=1 and both outputs valid on the next cycle.
- Both masters address 32'h60000000 (unmapped) in one cycle -> both wrrdys=1, errvld=1 for 1 cycle, erraddr=master 0 address, errcnt +2. Repeat until errcnt saturates at 16'hFFFF -> it stays there.
- Assert rst while rdvlds[2]=1 and rdrdys[2]=0 -> the next cycle shows rdvlds=0, errcnt=0, and RR restarting at master 0.

Source files
------------

// File: rtl/powlib_busxbar_if.sv
// Bus bundle between the crossbar, its bus masters and its memory-mapped slaves.
// The "slave" modport is the crossbar's view; "master" is the environment's view.
interface powlib_busxbar_if #(
   parameter int B_WRS = 2,
   parameter int B_RDS = 3,
   parameter int B_AW  = 32,
   parameter int B_DW  = 40
);
   logic [B_AW*B_WRS-1:0] wraddrs;
   logic [B_DW*B_WRS-1:0] wrdatas;
   logic [B_WRS-1:0]      wrvlds;
   logic [B_WRS-1:0]      wrrdys;
   logic [B_AW*B_RDS-1:0] rdaddrs;
   logic [B_DW*B_RDS-1:0] rddatas;
   logic [B_RDS-1:0]      rdvlds;
   logic [B_RDS-1:0]      rdrdys;

   modport slave (
      input  wraddrs, wrdatas, wrvlds, rdrdys,
      output wrrdys, rdaddrs, rddatas, rdvlds
   );

   modport master (
      output wraddrs, wrdatas, wrvlds, rdrdys,
      input  wrrdys, rdaddrs, rddatas, rdvlds
   );
endinterface

// File: rtl/powlib_busxbar.sv
// Single-clock bus crossbar: routes packed words from B_WRS masters to B_RDS
// slaves by address window, with a round-robin arbiter and a registered output
// stage per slave. Words to unmapped addresses are accepted, dropped and counted.
module powlib_busxbar #(
   parameter string ID    = "BUSXBAR",
   parameter int    EAR   = 0,
   parameter int    EDBG  = 0,
   parameter int    B_WRS = 2,
   parameter int    B_RDS = 3,
   parameter int    B_AW  = 32,
   parameter int    B_DW  = 40,
   parameter logic [B_AW*B_RDS-1:0] B_BASES = '0,
   parameter logic [B_AW*B_RDS-1:0] B_SIZES = {B_RDS{B_AW'('hFFFF)}},
   parameter int    ERRW  = 16
) (
   input  logic                clk,
   input  logic                rst,
   powlib_busxbar_if.slave     bus,
   output logic                errvld,
   output logic [B_AW-1:0]     erraddr,
   output logic [ERRW-1:0]     errcnt
);
   localparam int IW = (B_WRS > 1) ? $clog2(B_WRS) : 1;
   localparam int SW = (B_RDS > 1) ? $clog2(B_RDS) : 1;
   localparam int CW = $clog2(B_WRS + 1);

   // Per-master view after the optional input register.
   logic [B_WRS-1:0] in_vld;
   logic [B_WRS-1:0] in_rdy;
   logic [B_WRS-1:0] mapped;
   logic [B_WRS-1:0] drop;
   logic [B_AW-1:0]  in_addr [B_WRS];
   logic [B_DW-1:0]  in_data [B_WRS];
   logic [SW-1:0]    tgt     [B_WRS];

   // Per-slave arbitration results.
   logic [B_RDS-1:0] gnt_any;
   logic [B_RDS-1:0] free;
   logic [IW-1:0]    gnt_idx [B_RDS];

   genvar gi;
   genvar gj;

   for (gi = 0; gi < B_WRS; gi++) begin : g_mst
      logic          hit;
      logic [SW-1:0] sel;

      if (EAR != 0) begin : g_reg
         logic            vld_reg;
         logic [B_AW-1:0] addr_reg;
         logic [B_DW-1:0] data_reg;

         // Input stage: refill whenever empty or its word leaves this cycle.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_reg  <= 1'b0;
               addr_reg <= '0;
               data_reg <= '0;
            end else if (!vld_reg || in_rdy[gi]) begin
               vld_reg  <= bus.wrvlds[gi];
               addr_reg <= bus.wraddrs[gi*B_AW +: B_AW];
               data_reg <= bus.wrdatas[gi*B_DW +: B_DW];
            end
         end

         assign in_vld[gi]     = vld_reg;
         assign in_addr[gi]    = addr_reg;
         assign in_data[gi]    = data_reg;
         assign bus.wrrdys[gi] = !vld_reg || in_rdy[gi];
      end else begin : g_dir
         assign in_vld[gi]     = bus.wrvlds[gi];
         assign in_addr[gi]    = bus.wraddrs[gi*B_AW +: B_AW];
         assign in_data[gi]    = bus.wrdatas[gi*B_DW +: B_DW];
         assign bus.wrrdys[gi] = in_rdy[gi];
      end

      // Address decode: scan downwards so the lowest matching window wins.
      always_comb begin
         hit = 1'b0;
         sel = '0;
         for (int s = B_RDS - 1; s >= 0; s--) begin
            if ((in_addr[gi] >= B_BASES[s*B_AW +: B_AW]) &&
                ({1'b0, in_addr[gi]} <= ({1'b0, B_BASES[s*B_AW +: B_AW]} +
                                         {1'b0, B_SIZES[s*B_AW +: B_AW]}))) begin
               hit = 1'b1;
               sel = SW'(s);
            end
         end
      end

      assign mapped[gi] = hit;
      assign tgt[gi]    = sel;
      assign drop[gi]   = in_vld[gi] && !hit;
      // Unmapped words are always accepted so they can be discarded.
      assign in_rdy[gi] = !hit || (gnt_any[sel] && (gnt_idx[sel] == IW'(gi)) && free[sel]);
   end

   for (gj = 0; gj < B_RDS; gj++) begin : g_slv
      localparam logic [B_AW-1:0] BASE = B_BASES[gj*B_AW +: B_AW];

      logic            any;
      logic [IW-1:0]   idx;
      logic            xfer;
      logic [IW-1:0]   ptr_reg;
      logic            vld_reg;
      logic [B_AW-1:0] addr_reg;
      logic [B_DW-1:0] data_reg;

      assign free[gj] = !vld_reg || bus.rdrdys[gj];

      // Round-robin arbiter: first requester at or after the pointer, wrapping.
      always_comb begin
         int cand;
         any  = 1'b0;
         idx  = '0;
         cand = 0;
         for (int k = 0; k < B_WRS; k++) begin
            cand = int'(ptr_reg) + k;
            if (cand >= B_WRS) cand = cand - B_WRS;
            if (!any && in_vld[cand] && mapped[cand] && (tgt[cand] == SW'(gj))) begin
               any = 1'b1;
               idx = IW'(cand);
            end
         end
      end

      assign gnt_any[gj] = any;
      assign gnt_idx[gj] = idx;
      assign xfer        = any && free[gj];

      // Output register and pointer: load on transfer, clear when drained.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_reg  <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
            ptr_reg  <= '0;
         end else if (xfer) begin
            vld_reg  <= 1'b1;
            addr_reg <= in_addr[idx] - BASE;
            data_reg <= in_data[idx];
            ptr_reg  <= (idx == IW'(B_WRS - 1)) ? '0 : idx + 1'b1;
         end else if (bus.rdrdys[gj]) begin
            vld_reg  <= 1'b0;
         end
      end

      assign bus.rdvlds[gj]                 = vld_reg;
      assign bus.rdaddrs[gj*B_AW +: B_AW]   = addr_reg;
      assign bus.rddatas[gj*B_DW +: B_DW]   = data_reg;
   end

   // Drop accounting: number of dropped words and lowest-index dropped address.
   logic [CW-1:0]   drop_cnt;
   logic [B_AW-1:0] drop_addr;
   logic [ERRW:0]   cnt_sum;
   logic            errvld_reg;
   logic [B_AW-1:0] erraddr_reg;
   logic [ERRW-1:0] errcnt_reg;

   // Count drops and pick the first dropped master's address.
   always_comb begin
      logic found;
      drop_cnt  = '0;
      drop_addr = '0;
      found     = 1'b0;
      for (int i = 0; i < B_WRS; i++) begin
         if (drop[i]) begin
            drop_cnt = drop_cnt + CW'(1);
            if (!found) begin
               found     = 1'b1;
               drop_addr = in_addr[i];
            end
         end
      end
      cnt_sum = {1'b0, errcnt_reg} + (ERRW+1)'(drop_cnt);
   end

   // Error report registers with a saturating drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         errvld_reg  <= 1'b0;
         erraddr_reg <= '0;
         errcnt_reg  <= '0;
      end else begin
         errvld_reg <= |drop;
         if (|drop) erraddr_reg <= drop_addr;
         errcnt_reg <= cnt_sum[ERRW] ? '1 : cnt_sum[ERRW-1:0];
      end
   end

   assign errvld  = errvld_reg;
   assign erraddr = erraddr_reg;
   assign errcnt  = errcnt_reg;

   // Debug builds: a reported drop must always be reflected in the counter.
   always @(posedge clk) begin
      if (EDBG != 0 && !rst) begin
         assert (!errvld_reg || errcnt_reg != '0)
            else $error("%s: drop flagged with zero error count", ID);
      end
   end
endmodule
